pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard/stall sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  - Generates per-stage register write-enables and flush strobes.
//  - Covers: load-use stalls, taken-branch flushes (branch resolved in MEM), multi-cycle data-memory waits.
//  - Memory-wait watchdog and a stall performance counter.
//  - Sits beside the pipeline top; drives the pipeline-register enables and the PC enable.
// PARAMETERS
//  REG_AW     5     register-specifier width
//  TIMEOUT    64    max consecutive MEM_WAIT cycles before error (>=2)
//  CNT_W      16    width of stall_cnt (saturating)
// PORTS
//  clk           in   1       single clock, rising edge
//  reset         in   1       synchronous, active-high
//  id_rs         in   REG_AW  rs of instruction in ID
//  id_rt         in   REG_AW  rt of instruction in ID
//  id_uses_rt    in   1       ID instruction reads rt
//  ex_rt         in   REG_AW  destination of instruction in EX
//  ex_mem_read   in   1       EX instruction is a load
//  mem_branch    in   1       taken branch/jump resolved in MEM this cycle
//  dmem_req      in   1       MEM stage accessing data memory
//  dmem_ready    in   1       data memory completes access this cycle
//  pc_write      out  1       PC register enable
//  if_id_write   out  1       IF/ID enable
//  id_ex_write   out  1       ID/EX enable
//  ex_mem_write  out  1       EX/MEM enable
//  mem_wb_write  out  1       MEM/WB enable
//  if_id_flush   out  1       IF/ID -> NOP
//  id_ex_flush   out  1       ID/EX -> NOP (bubble)
//  ex_mem_flush  out  1       EX/MEM -> NOP
//  mem_err       out  1       sticky watchdog error
//  stall_cnt     out  CNT_W   cycles with pc_write==0, saturates at all-ones
// BEHAVIOUR
//  - Clock and reset: one clock (clk). reset is synchronous, active-high.
//  - During reset: state=RUN, mem_err=0, stall_cnt=0.
//  - Outputs in reset cycle: all *_write=1, all *_flush=0.
//  - States: RUN, MEM_WAIT, ERR (2-bit encoding).
//  - Outputs are Mealy: combinational from state and inputs. State and counters are registered.
//  - Definitions:
//    - mw = dmem_req & ~dmem_ready
//    - lu = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt))
//  - Priority each cycle: mw > mem_branch > lu.
//  - RUN, mw:
//    - all *_write=0, all flushes=0 (full freeze).
//    - -> MEM_WAIT; wait_cnt<=1.
//  - RUN, mem_branch & ~mw:
//    - all writes=1; if_id_flush, id_ex_flush, ex_mem_flush=1.
//    - PC loads the branch target. lu is ignored (the ID instruction is squashed).
//  - RUN, lu & ~mw & ~mem_branch:
//    - pc_write=0, if_id_write=0, id_ex_flush=1; other writes=1.
//    - Exactly one bubble. The hazard clears next cycle as the load moves to MEM.
//  - MEM_WAIT, ~dmem_ready:
//    - full freeze; wait_cnt++.
//    - If wait_cnt==TIMEOUT-1: -> ERR, mem_err<=1.
//  - MEM_WAIT, dmem_ready (exit cycle):
//    - Outputs as RUN with mw=0, so a pending mem_branch or lu applies in this same cycle.
//    - -> RUN.
//  - ERR: full freeze forever; mem_err=1. Exit only via reset.
//  - dmem_req drop during MEM_WAIT is treated as dmem_ready (exit).
//  - stall_cnt increments on every non-reset cycle with pc_write==0 (including ERR); saturates.
//  - Reset mid-MEM_WAIT or in ERR: next cycle is RUN with a clean counter and cleared error.
//  - wait_cnt: internal, width clog2(TIMEOUT).
// STRUCTURE
//  - Shared package pipe_pkg: state enum (RUN/MEM_WAIT/ERR), REG_AW, NOP-encoding constants.
//  - One sub-module: sat_counter (parameter W; inc, clr -> q). Used for stall_cnt and wait_cnt.
//  - Remainder is the FSM plus the output decode, in this module.
// TESTING
//  - Reset: reset=1 for 2 cycles -> all writes=1, flushes=0, stall_cnt=0, mem_err=0.
//  - Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt=1.
//  - Branch beats load-use: mem_branch=1 with the same lu -> 3 flushes=1, pc_write=1; stall_cnt unchanged.
//  - Mem wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles, release on the 4th; stall_cnt=3.
//  - Watchdog: TIMEOUT=4, dmem_ready held 0 -> ERR after 4 frozen cycles, mem_err=1; reset clears it.
//  - Zero register: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer: FSM states,
// per-stage control bundle and the NOP / freeze encodings of that bundle.
package pipe_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_e;

  // write = {pc, if_id, id_ex, ex_mem, mem_wb}; flush = {if_id, id_ex, ex_mem}
  typedef struct packed {
    logic [4:0] write;
    logic [2:0] flush;
  } ctrl_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam ctrl_t       CTRL_RUN    = '{write: 5'b11111, flush: 3'b000};
  localparam ctrl_t       CTRL_FREEZE = '{write: 5'b00000, flush: 3'b000};
  localparam ctrl_t       CTRL_BRANCH = '{write: 5'b11111, flush: 3'b111};
  localparam ctrl_t       CTRL_BUBBLE = '{write: 5'b00111, flush: 3'b010};

  // Decode when memory is not holding the pipe: a taken branch squashes the
  // ID instruction, so it outranks the load-use bubble.
  function automatic ctrl_t run_ctrl(input logic branch, input logic lu);
    if (branch)  return CTRL_BRANCH;
    else if (lu) return CTRL_BUBBLE;
    else         return CTRL_RUN;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset; clr restarts the count,
// and clr together with inc loads 1 so a fresh sequence can count its first cycle.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset)                q <= '0;
    else if (clr)             q <= W'(inc);
    else if (inc && !(&q))    q <= q + W'(1);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for a 5-stage pipeline: load-use bubbles, branch
// flushes, data-memory wait freezes with a watchdog, and a stall counter.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW  = pipe_pkg::REG_AW,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_mem_read,
  input  logic              mem_branch,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              ex_mem_write,
  output logic              mem_wb_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e            state_q, state_d;
  ctrl_t             ctrl;
  logic              mw, lu;
  logic              wait_inc, err_set;
  logic [WAIT_W-1:0] wait_cnt;

  // A dropped request inside MEM_WAIT counts as completion, which is exactly ~mw.
  assign mw = dmem_req & ~dmem_ready;
  assign lu = ex_mem_read && (ex_rt != '0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    ctrl     = CTRL_RUN;
    wait_inc = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (mw) begin
          ctrl     = CTRL_FREEZE;
          wait_inc = 1'b1;
          state_d  = S_MEM_WAIT;
        end else begin
          ctrl = run_ctrl(mem_branch, lu);
        end
      end
      S_MEM_WAIT: begin
        if (mw) begin
          ctrl     = CTRL_FREEZE;
          wait_inc = 1'b1;
          if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            state_d = S_ERR;
            err_set = 1'b1;
          end
        end else begin
          ctrl    = run_ctrl(mem_branch, lu);
          state_d = S_RUN;
        end
      end
      S_ERR:   ctrl = CTRL_FREEZE;
      default: begin
        ctrl    = CTRL_FREEZE;
        state_d = S_RUN;
      end
    endcase
    if (reset) ctrl = CTRL_RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_set) mem_err <= 1'b1;
    end
  end

  assign {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = ctrl.write;
  assign {if_id_flush, id_ex_flush, ex_mem_flush}                         = ctrl.flush;

  // Wait counter restarts whenever we are outside MEM_WAIT; entering loads 1.
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != S_MEM_WAIT),
    .inc   (wait_inc),
    .q     (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (~pc_write),
    .q     (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of single-cycle RUN-state
// vectors plus hand-written memory-wait, watchdog and saturation sequences.
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW  = 5;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rt;
  logic              id_uses_rt, ex_mem_read, mem_branch, dmem_req, dmem_ready;
  logic              pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic              if_id_flush, id_ex_flush, ex_mem_flush, mem_err;
  logic [CNT_W-1:0]  stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_rt        (ex_rt),
    .ex_mem_read  (ex_mem_read),
    .mem_branch   (mem_branch),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .id_ex_write  (id_ex_write),
    .ex_mem_write (ex_mem_write),
    .mem_wb_write (mem_wb_write),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt)
  );

  typedef struct {
    string             name;
    logic [REG_AW-1:0] rs, rt, xrt;
    logic              uses_rt, mread, branch, req, ready;
    logic [4:0]        exp_wr;
    logic [2:0]        exp_fl;
  } vec_t;

  localparam logic [4:0] W_ALL = 5'b11111, W_NONE = 5'b00000, W_BUB = 5'b00111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                       input logic uses, input logic [REG_AW-1:0] xrt, input logic mread,
                       input logic branch, input logic req, input logic ready);
    id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_rt = xrt;
    ex_mem_read = mread; mem_branch = branch; dmem_req = req; dmem_ready = ready;
  endtask

  // Compare the Mealy outputs mid-cycle, between the drive edge and the next rising edge.
  task automatic check_ctrl(input string name, input logic [4:0] wr, input logic [2:0] fl);
    #1;
    check({name, ".write"},
          {27'd0, pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}, {27'd0, wr});
    check({name, ".flush"}, {29'd0, if_id_flush, id_ex_flush, ex_mem_flush}, {29'd0, fl});
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);  // memory stall pending: reset must win
    for (int i = 0; i < cycles; i++) begin
      if (i > 0) @(negedge clk);
      check_ctrl($sformatf("reset_c%0d", i), W_ALL, 3'b000);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset.mem_err", 32'(mem_err), 32'd0);
  endtask

  vec_t vecs[$];
  int   exp_stall;

  initial begin
    reset = 1'b1;
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    vecs.push_back('{"idle",         5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W_ALL, 3'b000});
    vecs.push_back('{"lu_rs",        5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W_BUB, 3'b010});
    vecs.push_back('{"branch_vs_lu", 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, W_ALL, 3'b111});
    vecs.push_back('{"lu_rt",        5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, W_BUB, 3'b010});
    vecs.push_back('{"rt_unused",    5'd3, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W_ALL, 3'b000});
    vecs.push_back('{"zero_reg",     5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, W_ALL, 3'b000});
    vecs.push_back('{"not_load",     5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, W_ALL, 3'b000});
    vecs.push_back('{"branch_only",  5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, W_ALL, 3'b111});
    vecs.push_back('{"mem_hit_lu",   5'd9, 5'd2, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, W_BUB, 3'b010});
    vecs.push_back('{"ready_noreq",  5'd4, 5'd4, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, W_ALL, 3'b000});

    do_reset(2);

    // Single-cycle vectors, all from RUN; stall_cnt accumulates the bubbles.
    exp_stall = 0;
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].xrt, vecs[i].mread,
            vecs[i].branch, vecs[i].req, vecs[i].ready);
      check_ctrl(vecs[i].name, vecs[i].exp_wr, vecs[i].exp_fl);
      if (!vecs[i].exp_wr[4]) exp_stall++;
      @(posedge clk);
      #1;
      check({vecs[i].name, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    end

    // Memory wait: three frozen cycles, then release with a pending branch.
    do_reset(1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive('0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_ctrl($sformatf("mw_freeze%0d", c), W_NONE, 3'b000);
    end
    @(negedge clk);
    drive('0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_ctrl("mw_release_branch", W_ALL, 3'b111);
    @(negedge clk);
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ctrl("mw_back_to_run", W_ALL, 3'b000);
    check("mw.stall_cnt", 32'(stall_cnt), 32'd3);

    // Request dropped inside MEM_WAIT counts as completion; pending load-use applies.
    do_reset(1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_ctrl($sformatf("drop_freeze%0d", c), W_NONE, 3'b000);
    end
    @(negedge clk);
    drive(5'd6, '0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    check_ctrl("drop_exit_lu", W_BUB, 3'b010);
    @(negedge clk);
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ctrl("drop_run", W_ALL, 3'b000);
    check("drop.stall_cnt", 32'(stall_cnt), 32'd3);

    // Watchdog: TIMEOUT frozen cycles, then sticky ERR with saturating stall_cnt.
    do_reset(1);
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk);
      drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_ctrl($sformatf("wd_freeze%0d", c), W_NONE, 3'b000);
      check($sformatf("wd_err_pre%0d", c), 32'(mem_err), 32'd0);
    end
    @(negedge clk);
    drive('0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_ctrl("err_frozen", W_NONE, 3'b000);
    check("err.mem_err", 32'(mem_err), 32'd1);
    check("err.stall_cnt", 32'(stall_cnt), 32'(TIMEOUT));
    for (int c = 0; c < 5; c++) @(negedge clk);
    check_ctrl("err_still_frozen", W_NONE, 3'b000);
    check("err.stall_sat", 32'(stall_cnt), 32'((1 << CNT_W) - 1));
    check("err.mem_err_sticky", 32'(mem_err), 32'd1);

    do_reset(1);
    @(negedge clk);
    check_ctrl("post_err_run", W_ALL, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
